// File: rtl/axi_wr_arbiter_2to1_if.sv
// AXI4 write-path bundle (AW/W/B) carrying N packed ports side by side.
// The arbiter sees its two upstream masters through the slave modport (N=2)
// and drives the downstream memory-mapped slave through the master modport (N=1).
interface axi_wr_arbiter_2to1_if #(
    parameter int N          = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [N*ADDR_WIDTH-1:0] AWADDR;
    logic [N*8-1:0]          AWLEN;
    logic [N*3-1:0]          AWSIZE;
    logic [N-1:0]            AWVALID;
    logic [N-1:0]            AWREADY;
    logic [N*DATA_WIDTH-1:0] WDATA;
    logic [N-1:0]            WLAST;
    logic [N-1:0]            WVALID;
    logic [N-1:0]            WREADY;
    logic [N*2-1:0]          BRESP;
    logic [N-1:0]            BVALID;
    logic [N-1:0]            BREADY;

    // Issuer of write transactions.
    modport master (
        output AWADDR, AWLEN, AWSIZE, AWVALID,
        input  AWREADY,
        output WDATA, WLAST, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY
    );

    // Receiver of write transactions.
    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWVALID,
        output AWREADY,
        input  WDATA, WLAST, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_wr_arbiter_2to1.sv
// Two-master to one-slave AXI4 write arbiter. A master owns the slave for a
// whole AW -> W burst -> B transaction, then ownership alternates round-robin.
// Slave WLAST is regenerated from a beat counter; master WLAST is only checked.
module axi_wr_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      ARESET,
    axi_wr_arbiter_2to1_if.slave      m_if,
    axi_wr_arbiter_2to1_if.master     s_if,
    output logic                      grant,
    output logic                      busy,
    output logic                      wlast_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t     r_state, w_state_nxt;
    logic       r_grant, w_grant_nxt;
    logic       r_rr_ptr, w_rr_ptr_nxt;
    logic [7:0] r_beat_cnt, w_beat_cnt_nxt;
    logic [7:0] r_len_q, w_len_q_nxt;
    logic       r_wlast_err, w_wlast_err_nxt;
    logic       r_busy;

    logic       w_last_beat;
    logic       w_m_awvalid, w_m_wvalid, w_m_wlast, w_m_bready;
    logic [7:0] w_m_awlen;
    logic       w_s_awvalid, w_s_wvalid, w_s_wlast, w_s_bready;
    logic [1:0] w_m_awready, w_m_wready, w_m_bvalid;

    // Granted master's controls; payloads are muxed straight to the slave below.
    assign w_m_awvalid = r_grant ? m_if.AWVALID[1] : m_if.AWVALID[0];
    assign w_m_wvalid  = r_grant ? m_if.WVALID[1]  : m_if.WVALID[0];
    assign w_m_wlast   = r_grant ? m_if.WLAST[1]   : m_if.WLAST[0];
    assign w_m_bready  = r_grant ? m_if.BREADY[1]  : m_if.BREADY[0];
    assign w_m_awlen   = r_grant ? m_if.AWLEN[15:8] : m_if.AWLEN[7:0];
    assign w_last_beat = (r_beat_cnt == r_len_q);

    // Next-state, arbitration and handshake routing for the transaction FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_len_q_nxt     = r_len_q;
        w_wlast_err_nxt = 1'b0;
        w_s_awvalid     = 1'b0;
        w_s_wvalid      = 1'b0;
        w_s_wlast       = 1'b0;
        w_s_bready      = 1'b0;
        w_m_awready     = 2'b00;
        w_m_wready      = 2'b00;
        w_m_bvalid      = 2'b00;
        case (r_state)
            IDLE: begin
                if (m_if.AWVALID == 2'b01) begin
                    w_grant_nxt = 1'b0;
                    w_state_nxt = ADDR;
                end else if (m_if.AWVALID == 2'b10) begin
                    w_grant_nxt = 1'b1;
                    w_state_nxt = ADDR;
                end else if (m_if.AWVALID == 2'b11) begin
                    w_grant_nxt = r_rr_ptr;
                    w_state_nxt = ADDR;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ADDR: begin
                w_s_awvalid          = w_m_awvalid;
                w_m_awready[r_grant] = s_if.AWREADY[0];
                if (w_m_awvalid && s_if.AWREADY[0]) begin
                    w_len_q_nxt    = w_m_awlen;
                    w_beat_cnt_nxt = 8'd0;
                    w_state_nxt    = DATA;
                end else begin
                    w_state_nxt = ADDR;
                end
            end
            DATA: begin
                w_s_wvalid          = w_m_wvalid;
                w_s_wlast           = w_last_beat;
                w_m_wready[r_grant] = s_if.WREADY[0];
                if (w_m_wvalid && s_if.WREADY[0]) begin
                    // Counter wraps only on the final beat of a 256-beat burst,
                    // at the same edge the FSM leaves DATA.
                    w_beat_cnt_nxt  = r_beat_cnt + 8'd1;
                    w_wlast_err_nxt = (w_m_wlast != w_last_beat);
                    if (w_last_beat) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end else begin
                    w_state_nxt = DATA;
                end
            end
            RESP: begin
                w_s_bready          = w_m_bready;
                w_m_bvalid[r_grant] = s_if.BVALID[0];
                if (s_if.BVALID[0] && w_m_bready) begin
                    w_rr_ptr_nxt = ~r_grant;
                    w_state_nxt  = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_grant     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_beat_cnt  <= 8'd0;
            r_len_q     <= 8'd0;
            r_wlast_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_len_q     <= w_len_q_nxt;
            r_wlast_err <= w_wlast_err_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign grant     = r_grant;
    assign busy      = r_busy;
    assign wlast_err = r_wlast_err;

    assign s_if.AWADDR  = r_grant ? m_if.AWADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_if.AWADDR[ADDR_WIDTH-1:0];
    assign s_if.AWLEN   = w_m_awlen;
    assign s_if.AWSIZE  = r_grant ? m_if.AWSIZE[5:3] : m_if.AWSIZE[2:0];
    assign s_if.AWVALID = w_s_awvalid;
    assign s_if.WDATA   = r_grant ? m_if.WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : m_if.WDATA[DATA_WIDTH-1:0];
    assign s_if.WLAST   = w_s_wlast;
    assign s_if.WVALID  = w_s_wvalid;
    assign s_if.BREADY  = w_s_bready;

    assign m_if.AWREADY = w_m_awready;
    assign m_if.WREADY  = w_m_wready;
    assign m_if.BVALID  = w_m_bvalid;
    assign m_if.BRESP   = {2{s_if.BRESP}};

endmodule

// File: tb/tb_axi_wr_arbiter_2to1.sv
// Directed bench for axi_wr_arbiter_2to1: bench plays both masters and the slave.
module tb_axi_wr_arbiter_2to1;

    logic clk;
    logic ARESET;
    logic grant, busy, wlast_err;
    int   n_assert;
    int   n_fail;

    axi_wr_arbiter_2to1_if #(.N(2), .ADDR_WIDTH(16), .DATA_WIDTH(32)) mif ();
    axi_wr_arbiter_2to1_if #(.N(1), .ADDR_WIDTH(16), .DATA_WIDTH(32)) sif ();

    axi_wr_arbiter_2to1 #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .ARESET   (ARESET),
        .m_if     (mif),
        .s_if     (sif),
        .grant    (grant),
        .busy     (busy),
        .wlast_err(wlast_err)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_wlast_err", wlast_err, 1'b0);
        chk("rst_s_awvalid", sif.AWVALID, 1'b0);
        chk("rst_m_awready", mif.AWREADY, 2'b00);
        step();
    endtask

    // One full transaction by master m, entered from IDLE just after an edge.
    // wl_extra marks beats on which the master raises WLAST early.
    task automatic do_txn(input int m, input logic [7:0] len, input logic [15:0] addr,
                          input logic [31:0] dbase, input logic [7:0] wl_extra,
                          input logic [1:0] resp);
        logic [1:0] oh;
        logic       wl;
        logic       exp_err;
        oh = (m == 0) ? 2'b01 : 2'b10;
        mif.AWVALID[m]        = 1'b1;
        mif.AWADDR[m*16 +: 16] = addr;
        mif.AWLEN[m*8 +: 8]    = len;
        mif.AWSIZE[m*3 +: 3]   = 3'd2;
        sif.AWREADY = 1'b1;
        sif.WREADY  = 1'b1;
        @(negedge clk);
        chk("idle_s_awvalid", sif.AWVALID, 1'b0);
        chk("idle_busy", busy, 1'b0);
        step();
        @(negedge clk);
        chk("addr_grant", grant, m[0]);
        chk("addr_s_awvalid", sif.AWVALID, 1'b1);
        chk("addr_s_awaddr", sif.AWADDR, addr);
        chk("addr_s_awlen", sif.AWLEN, len);
        chk("addr_m_awready", mif.AWREADY, oh);
        chk("addr_busy", busy, 1'b1);
        step();
        mif.AWVALID[m] = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wl = (i == int'(len)) || (i < 8 && wl_extra[i]);
            mif.WVALID[m] = 1'b1;
            mif.WDATA[m*32 +: 32] = dbase + 32'(i);
            mif.WLAST[m] = wl;
            @(negedge clk);
            chk("data_s_wvalid", sif.WVALID, 1'b1);
            chk("data_s_wdata", sif.WDATA, dbase + 32'(i));
            chk("data_s_wlast", sif.WLAST, (i == int'(len)));
            chk("data_m_wready", mif.WREADY, oh);
            chk("data_m_awready", mif.AWREADY, 2'b00);
            chk("data_wlast_err", wlast_err, exp_err);
            exp_err = (wl != (i == int'(len)));
            step();
        end
        mif.WVALID[m] = 1'b0;
        mif.WLAST[m]  = 1'b0;
        mif.BREADY[m] = 1'b1;
        sif.BVALID    = 1'b0;
        @(negedge clk);
        chk("resp_wlast_err", wlast_err, exp_err);
        chk("resp_s_wvalid", sif.WVALID, 1'b0);
        chk("resp_s_bready", sif.BREADY, 1'b1);
        chk("resp_m_bvalid_wait", mif.BVALID, 2'b00);
        step();
        sif.BVALID = 1'b1;
        sif.BRESP  = resp;
        @(negedge clk);
        chk("resp_m_bvalid", mif.BVALID, oh);
        chk("resp_m_bresp", mif.BRESP, {resp, resp});
        chk("resp_wlast_err_clr", wlast_err, 1'b0);
        step();
        sif.BVALID    = 1'b0;
        mif.BREADY[m] = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        ARESET = 1'b1;
        mif.AWADDR = '0; mif.AWLEN = '0; mif.AWSIZE = '0; mif.AWVALID = '0;
        mif.WDATA = '0; mif.WLAST = '0; mif.WVALID = '0; mif.BREADY = '0;
        sif.AWREADY = 1'b1; sif.WREADY = 1'b1; sif.BRESP = 2'b00; sif.BVALID = 1'b0;
        step();

        // 1: single master, 4-beat burst
        do_reset();
        do_txn(0, 8'd3, 16'h0100, 32'h0000_00A0, 8'h00, 2'b01);

        // 2: simultaneous requests after reset -> m0 then m1
        do_reset();
        mif.AWVALID[1] = 1'b1;
        do_txn(0, 8'd1, 16'h0200, 32'h0000_0010, 8'h00, 2'b00);
        do_txn(1, 8'd1, 16'h0300, 32'h0000_0020, 8'h00, 2'b10);

        // 3: both requesting continuously, AWLEN=0 -> grants 0,1,0,1
        mif.AWVALID = 2'b11;
        do_txn(0, 8'd0, 16'h1000, 32'h0000_0100, 8'h00, 2'b00);
        mif.AWVALID = 2'b11;
        do_txn(1, 8'd0, 16'h1100, 32'h0000_0200, 8'h00, 2'b00);
        mif.AWVALID = 2'b11;
        do_txn(0, 8'd0, 16'h1200, 32'h0000_0300, 8'h00, 2'b11);
        mif.AWVALID = 2'b11;
        do_txn(1, 8'd0, 16'h1300, 32'h0000_0400, 8'h00, 2'b00);

        // 4: m1 AWLEN=2 with early WLAST on beat 2 -> one wlast_err pulse
        mif.AWVALID = 2'b00;
        do_txn(1, 8'd2, 16'h4000, 32'h0000_0500, 8'h02, 2'b00);

        // 5: reset during DATA after 2 of 8 beats (m1), then a normal m0 request
        mif.AWVALID[1] = 1'b1;
        mif.AWLEN[15:8] = 8'd7;
        mif.AWADDR[31:16] = 16'h5000;
        step();
        @(negedge clk);
        chk("t5_grant_m1", grant, 1'b1);
        step();
        mif.AWVALID[1] = 1'b0;
        mif.WVALID[1]  = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("t5_in_data", sif.WVALID, 1'b1);
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 1'b0);
        chk("t5_s_wvalid", sif.WVALID, 1'b0);
        chk("t5_grant", grant, 1'b0);
        chk("t5_m_wready", mif.WREADY, 2'b00);
        mif.WVALID[1] = 1'b0;
        step();
        do_txn(0, 8'd1, 16'h0600, 32'h0000_0600, 8'h00, 2'b00);

        // 6: AWLEN=255 with WREADY toggling -> 256 beats, WLAST only on last
        begin
            int exp_hs;
            int cyc;
            mif.AWVALID[0]  = 1'b1;
            mif.AWLEN[7:0]  = 8'd255;
            mif.AWADDR[15:0] = 16'h2000;
            step();
            @(negedge clk);
            chk("t6_s_awlen", sif.AWLEN, 8'd255);
            step();
            mif.AWVALID[0] = 1'b0;
            exp_hs = 0;
            cyc = 0;
            while (exp_hs < 256) begin
                mif.WVALID[0]     = 1'b1;
                mif.WDATA[31:0]   = 32'(exp_hs);
                mif.WLAST[0]      = (exp_hs == 255);
                sif.WREADY        = (cyc % 2 == 1);
                @(negedge clk);
                chk("t6_s_wvalid", sif.WVALID, 1'b1);
                chk("t6_s_wdata", sif.WDATA, 32'(exp_hs));
                chk("t6_s_wlast", sif.WLAST, (exp_hs == 255));
                if (sif.WREADY) begin
                    exp_hs++;
                end
                step();
                cyc++;
            end
            mif.WVALID[0] = 1'b0;
            mif.WLAST[0]  = 1'b0;
            mif.BREADY[0] = 1'b1;
            sif.WREADY    = 1'b1;
            @(negedge clk);
            chk("t6_resp_s_wvalid", sif.WVALID, 1'b0);
            chk("t6_resp_busy", busy, 1'b1);
            chk("t6_resp_s_bready", sif.BREADY, 1'b1);
            chk("t6_wlast_err", wlast_err, 1'b0);
            sif.BVALID = 1'b1;
            step();
            sif.BVALID    = 1'b0;
            mif.BREADY[0] = 1'b0;
            @(negedge clk);
            chk("t6_done_busy", busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
